// File: rtl/hex_record_arbiter_pkg.sv
// Shared definitions for hex_record_arbiter and its helpers.
//   - ASCII constants used when formatting a record line.
//   - hexdigit(): nibble to uppercase ASCII hex character.
//   - state_t: line scheduler states.
package hex_record_arbiter_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_COLON = 8'h3A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] hexdigit(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/hex_record_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick among up to 16 requesters.
//   clk, reset : clock, asynchronous active-high reset (pointer returns to 0)
//   req        : request vector
//   advance    : when high and a request is granted, the pointer moves to
//                (granted index + 1) mod NUM_REQ at the next clock edge
//   gnt        : one-hot grant (all zero when nothing requests)
//   gnt_idx    : binary index of the granted requester
// The search starts at the pointer and wraps; the first requester found wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [3:0]         gnt_idx
);

    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] req_ext;
    logic [4:0]  cand;
    logic        found;

    // Zero-extended copy so the search can index with a fixed 4-bit value
    // whatever NUM_REQ is.
    assign req_ext = 16'(req);

    always_comb begin
        found   = 1'b0;
        gnt_idx = 4'h0;
        cand    = 5'h00;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = 5'(ptr_q) + 5'(off);
            if (cand >= 5'(NUM_REQ)) begin
                cand = cand - 5'(NUM_REQ);
            end
            if (!found && req_ext[cand[3:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[3:0];
            end
        end
        gnt = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gnt_idx == 4'(NUM_REQ - 1)) ? 4'h0 : gnt_idx + 4'h1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 4'h0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hex_record_arbiter.sv
// hex_record_arbiter: shares one UART byte stream among NUM_SRC record FIFOs.
// Picks a non-empty source round-robin, pops one record and prints it as a
// line of uppercase hex: digits MS nibble first, an optional space after
// SPACE_AFTER digits, then LF, CR.
// Build option HEX_RECORD_ARBITER_SOURCE_TAG_EN: prefix each line with the
// source index as one hex digit and ':'.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   src_available   : per-source FIFO non-empty flags
//   src_data        : per-source head words, source i at [i*WIDTH +: WIDTH]
//   src_read_strobe : one-cycle pop pulse to the granted source
//   tx_ready        : downstream byte FIFO can take a byte this cycle
//   tx_data         : ASCII byte, valid while tx_strobe is high
//   tx_strobe       : write pulse; only ever high while tx_ready is high
//   busy            : high from the pop until the CR byte is issued
//   grant           : index of the source currently or last served
// Handshake: a byte transfers in any cycle where tx_strobe && tx_ready; the
// strobe is formed combinationally from tx_ready so it never fires while the
// downstream FIFO is full, and the byte index/shift register hold otherwise.
module hex_record_arbiter
    import hex_record_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int WIDTH       = 28,
    parameter int SPACE_AFTER = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       src_available,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]       src_read_strobe,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_strobe,
    output logic                     busy,
    output logic [3:0]               grant
);

    localparam int NUM_DIGITS = WIDTH / 4;
    localparam int SPACE_EN   = (SPACE_AFTER > 0 && SPACE_AFTER < NUM_DIGITS) ? 1 : 0;
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
    localparam int TAG_LEN    = 2;
`else
    localparam int TAG_LEN    = 0;
`endif
    localparam int SPACE_IDX  = TAG_LEN + SPACE_AFTER;
    localparam int LINE_LEN   = TAG_LEN + NUM_DIGITS + SPACE_EN + 2;
    localparam int IDX_W      = $clog2(LINE_LEN + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [3:0]           grant_q, grant_d;
    logic [NUM_SRC-1:0]   src_read_strobe_q, src_read_strobe_d;
    logic [NUM_SRC-1:0]   holdoff_q, holdoff_d;

    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   arb_gnt;
    logic [3:0]           arb_idx;
    logic                 pop;
    logic                 pop_phase;
    logic [WIDTH-1:0]     captured;
    logic [7:0]           line_byte;
    logic                 is_digit;

    // A just-popped source may still show a stale available flag for a cycle.
    assign eligible  = src_available & ~holdoff_q;
    assign pop       = (state_q == ST_IDLE) && (|eligible);
    // No byte goes out in the pop cycle itself.
    assign pop_phase = |src_read_strobe_q;

    rr_arbiter #(.NUM_REQ(NUM_SRC)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (pop),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        captured = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_idx == 4'(i)) begin
                captured = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Byte at the current line position; digits always come from the top
    // nibble of the shift register, which moves only when a digit is taken.
    always_comb begin
        line_byte = 8'h00;
        is_digit  = 1'b0;
        if (idx_q == IDX_W'(LINE_LEN - 1)) begin
            line_byte = CHAR_CR;
        end else if (idx_q == IDX_W'(LINE_LEN - 2)) begin
            line_byte = CHAR_LF;
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
        end else if (idx_q == IDX_W'(0)) begin
            line_byte = hexdigit(grant_q);
        end else if (idx_q == IDX_W'(1)) begin
            line_byte = CHAR_COLON;
`endif
        end else if (SPACE_EN != 0 && idx_q == IDX_W'(SPACE_IDX)) begin
            line_byte = CHAR_SPACE;
        end else begin
            line_byte = hexdigit(shift_q[WIDTH-1 -: 4]);
            is_digit  = 1'b1;
        end
    end

    assign tx_strobe       = (state_q == ST_EMIT) && !pop_phase && tx_ready;
    assign tx_data         = tx_strobe ? line_byte : 8'h00;
    assign busy            = (state_q == ST_EMIT);
    assign grant           = grant_q;
    assign src_read_strobe = src_read_strobe_q;

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        shift_d           = shift_q;
        grant_d           = grant_q;
        src_read_strobe_d = '0;
        holdoff_d         = src_read_strobe_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d           = ST_EMIT;
                    src_read_strobe_d = arb_gnt;
                    grant_d           = arb_idx;
                    shift_d           = captured;
                    idx_d             = '0;
                end
            end
            ST_EMIT: begin
                if (tx_strobe) begin
                    if (is_digit) begin
                        shift_d = shift_q << 4;
                    end
                    if (idx_q == IDX_W'(LINE_LEN - 1)) begin
                        // Index parks at the line length until the next pop.
                        state_d = ST_IDLE;
                        idx_d   = IDX_W'(LINE_LEN);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            idx_q             <= '0;
            shift_q           <= '0;
            grant_q           <= 4'h0;
            src_read_strobe_q <= '0;
            holdoff_q         <= '0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            shift_q           <= shift_d;
            grant_q           <= grant_d;
            src_read_strobe_q <= src_read_strobe_d;
            holdoff_q         <= holdoff_d;
        end
    end

endmodule

// File: tb/tb_hex_record_arbiter.sv
`timescale 1ns/1ps
module tb_hex_record_arbiter;

    localparam int NUM_SRC     = 2;
    localparam int WIDTH       = 28;
    localparam int SPACE_AFTER = 3;
    localparam int ND          = WIDTH / 4;
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
    localparam int LINE_LEN = 12;
`else
    localparam int LINE_LEN = 10;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_SRC-1:0]       src_available;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_read_strobe;
    logic                     tx_ready;
    logic [7:0]               tx_data;
    logic                     tx_strobe;
    logic                     busy;
    logic [3:0]               grant;

    hex_record_arbiter #(
        .NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .SPACE_AFTER(SPACE_AFTER)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .src_available   (src_available),
        .src_data        (src_data),
        .src_read_strobe (src_read_strobe),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .tx_strobe       (tx_strobe),
        .busy            (busy),
        .grant           (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int obs_base = 0;

    logic [WIDTH-1:0] src_q [NUM_SRC][$];
    int               stale_cnt [NUM_SRC];
    int               stale_len   = 0;
    int               ready_mode  = 0;
    int               ready_phase = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_bytes[$];
    int         obs_byte_cyc[$];
    int         obs_pop_src[$];
    int         obs_pop_cyc[$];
    bit         busy_hist[$];
    int         viol    = 0;
    int         pop_bad = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] hex_char(input int nib);
        return 8'(nib < 10 ? 48 + nib : 55 + nib);
    endfunction

    // Appends the expected text line for one record of source src.
    function automatic void push_line(input int src, input logic [WIDTH-1:0] rec);
        logic [WIDTH-1:0] t;
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
        exp_q.push_back(hex_char(src));
        exp_q.push_back(8'h3A);
`endif
        for (int d = 0; d < ND; d++) begin
            t = rec >> (4 * (ND - 1 - d));
            exp_q.push_back(hex_char(int'(t[3:0])));
            if (SPACE_AFTER > 0 && SPACE_AFTER < ND && d + 1 == SPACE_AFTER)
                exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
        if (src < 0) exp_q.delete();
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUM_SRC; i++)
            if (src_q[i].size() != 0 || stale_cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- drivers / monitor ----------------
    task automatic drive_inputs();
        logic [NUM_SRC-1:0]       av;
        logic [NUM_SRC*WIDTH-1:0] dat;
        av  = '0;
        dat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                av[i] = 1'b1;
                dat[i*WIDTH +: WIDTH] = src_q[i][0];
            end else if (stale_cnt[i] > 0) begin
                av[i] = 1'b1;
                dat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
        src_available = av;
        src_data      = dat;
        case (ready_mode)
            1:       tx_ready = 1'($urandom_range(0, 1));
            2: begin tx_ready = (ready_phase % 3 == 0); ready_phase++; end
            default: tx_ready = 1'b1;
        endcase
    endtask

    // One clock: sample outputs at the falling edge, then update the FIFO
    // model and drive new inputs just after the rising edge.
    task automatic step();
        logic [NUM_SRC-1:0] pops;
        @(negedge clk);
        pops = src_read_strobe;
        busy_hist.push_back(busy);
        if (tx_strobe === 1'b1) begin
            obs_bytes.push_back(tx_data);
            obs_byte_cyc.push_back(cyc);
            if (tx_ready !== 1'b1) viol++;
        end
        if (pops != '0) begin
            if ($countones(pops) != 1) pop_bad++;
            for (int i = 0; i < NUM_SRC; i++)
                if (pops[i]) begin
                    obs_pop_src.push_back(i);
                    obs_pop_cyc.push_back(cyc);
                end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pops[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                stale_cnt[i] = stale_len;
            end else if (stale_cnt[i] > 0) begin
                stale_cnt[i]--;
            end
        end
        drive_inputs();
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        obs_byte_cyc.delete();
        obs_pop_src.delete();
        obs_pop_cyc.delete();
        busy_hist.delete();
        viol     = 0;
        pop_bad  = 0;
        obs_base = cyc;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_q[i].delete();
            stale_cnt[i] = 0;
        end
        exp_q.delete();
        stale_len  = 0;
        ready_mode = 0;
        reset = 1'b1;
        drive_inputs();
        repeat (3) step();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic drain(input int budget, output bit timed_out);
        int quiet;
        quiet     = 0;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (all_empty() && busy_hist[busy_hist.size()-1] == 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (src_read_strobe !== '0) begin bad++; $display("FAIL reset_strobe: got %b want 0", src_read_strobe); end
        total++; if (tx_strobe !== 1'b0) begin bad++; $display("FAIL reset_tx_strobe: got %b want 0", tx_strobe); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant); end
        repeat (5) step();
        total++; if (obs_pop_src.size() != 0) begin bad++; $display("FAIL idle_pops: got %0d want 0", obs_pop_src.size()); end
        total++; if (obs_bytes.size() != 0) begin bad++; $display("FAIL idle_bytes: got %0d want 0", obs_bytes.size()); end
    endtask

    task automatic test_single_line();
        logic [7:0] exp_b [LINE_LEN];
        bit to;
        int busy_cnt;
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
        exp_b = '{8'h30, 8'h3A, 8'h41, 8'h31, 8'h42, 8'h20, 8'h32, 8'h43, 8'h33, 8'h44, 8'h0A, 8'h0D};
`else
        exp_b = '{8'h41, 8'h31, 8'h42, 8'h20, 8'h32, 8'h43, 8'h33, 8'h44, 8'h0A, 8'h0D};
`endif
        do_reset();
        src_q[0].push_back(28'hA1B2C3D);
        drive_inputs();
        drain(80, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", to); end
        total++; if (obs_pop_src.size() != 1) begin bad++; $display("FAIL single_pops: got %0d want 1", obs_pop_src.size()); end
        total++; if (obs_bytes.size() != LINE_LEN) begin bad++; $display("FAIL single_len: got %0d want %0d", obs_bytes.size(), LINE_LEN); end
        for (int k = 0; k < LINE_LEN; k++) begin
            total++;
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_b[k]) begin
                bad++;
                $display("FAIL single_byte[%0d]: got %h want %h", k, (k < obs_bytes.size()) ? obs_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
        if (obs_pop_cyc.size() == 1 && obs_byte_cyc.size() == LINE_LEN) begin
            total++; if (obs_byte_cyc[0] - obs_pop_cyc[0] != 1) begin bad++; $display("FAIL single_first_lat: got %0d want 1", obs_byte_cyc[0] - obs_pop_cyc[0]); end
            total++; if (obs_byte_cyc[LINE_LEN-1] - obs_pop_cyc[0] != LINE_LEN) begin bad++; $display("FAIL single_last_lat: got %0d want %0d", obs_byte_cyc[LINE_LEN-1] - obs_pop_cyc[0], LINE_LEN); end
        end
        busy_cnt = 0;
        foreach (busy_hist[i]) if (busy_hist[i]) busy_cnt++;
        total++; if (busy_cnt != LINE_LEN + 1) begin bad++; $display("FAIL single_busy_cycles: got %0d want %0d", busy_cnt, LINE_LEN + 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_alternate();
        logic [WIDTH-1:0] recs [2][3];
        bit to;
        int nerr;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 2; s++) begin
                recs[s][r] = WIDTH'($urandom);
                src_q[s].push_back(recs[s][r]);
            end
        for (int r = 0; r < 3; r++) begin
            push_line(0, recs[0][r]);
            push_line(1, recs[1][r]);
        end
        drive_inputs();
        drain(200, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL alt_timeout: got %b want 0", to); end
        total++; if (obs_pop_src.size() != 6) begin bad++; $display("FAIL alt_pops: got %0d want 6", obs_pop_src.size()); end
        total++; if (pop_bad != 0) begin bad++; $display("FAIL alt_onehot: got %0d bad strobes want 0", pop_bad); end
        for (int k = 0; k < 6 && k < obs_pop_src.size(); k++) begin
            total++; if (obs_pop_src[k] != k % 2) begin bad++; $display("FAIL alt_grant[%0d]: got %0d want %0d", k, obs_pop_src[k], k % 2); end
        end
        total++; if (obs_bytes.size() != exp_q.size()) begin bad++; $display("FAIL alt_len: got %0d want %0d", obs_bytes.size(), exp_q.size()); end
        nerr = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_q[k]) nerr++;
        total++; if (nerr != 0) begin bad++; $display("FAIL alt_bytes: got %0d wrong bytes want 0", nerr); end
        if (obs_pop_src.size() == 6 && obs_byte_cyc.size() == 6 * LINE_LEN) begin
            for (int k = 1; k < 6; k++) begin
                total++;
                if (obs_pop_cyc[k] - obs_byte_cyc[k*LINE_LEN-1] > 2) begin
                    bad++;
                    $display("FAIL alt_gap[%0d]: got %0d cycles want <=2", k, obs_pop_cyc[k] - obs_byte_cyc[k*LINE_LEN-1]);
                end
            end
        end
        total++; if (grant !== 4'd1) begin bad++; $display("FAIL alt_last_grant: got %0d want 1", grant); end
    endtask

    task automatic test_stall();
        bit to;
        int nerr;
        do_reset();
        ready_mode  = 2;
        ready_phase = 0;
        src_q[0].push_back(WIDTH'($urandom));
        push_line(0, src_q[0][0]);
        drive_inputs();
        drain(150, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %b want 0", to); end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_ready: got %0d bytes without tx_ready want 0", viol); end
        total++; if (obs_pop_src.size() != 1) begin bad++; $display("FAIL stall_pops: got %0d want 1", obs_pop_src.size()); end
        total++; if (obs_bytes.size() != LINE_LEN) begin bad++; $display("FAIL stall_len: got %0d want %0d", obs_bytes.size(), LINE_LEN); end
        nerr = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_q[k]) nerr++;
        total++; if (nerr != 0) begin bad++; $display("FAIL stall_bytes: got %0d wrong bytes want 0", nerr); end
        if (obs_byte_cyc.size() == LINE_LEN) begin
            total++;
            if (obs_byte_cyc[LINE_LEN-1] - obs_byte_cyc[0] < 2 * (LINE_LEN - 1)) begin
                bad++;
                $display("FAIL stall_spread: got %0d cycles want >=%0d", obs_byte_cyc[LINE_LEN-1] - obs_byte_cyc[0], 2 * (LINE_LEN - 1));
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] rec_b;
        bit to;
        int nerr;
        do_reset();
        src_q[1].push_back(WIDTH'($urandom));
        rec_b = WIDTH'($urandom);
        src_q[1].push_back(rec_b);
        drive_inputs();
        for (int k = 0; k < 40 && obs_bytes.size() < 4; k++) step();
        total++; if (obs_bytes.size() != 4) begin bad++; $display("FAIL midrst_reach: got %0d bytes want 4", obs_bytes.size()); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (tx_strobe !== 1'b0) begin bad++; $display("FAIL midrst_tx_strobe: got %b want 0", tx_strobe); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx_data: got %h want 00", tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL midrst_grant: got %0d want 0", grant); end
        total++; if (src_read_strobe !== '0) begin bad++; $display("FAIL midrst_strobe: got %b want 0", src_read_strobe); end
        clear_obs();
        repeat (2) step();
        reset = 1'b0;
        push_line(1, rec_b);
        drain(80, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL midrst_timeout: got %b want 0", to); end
        total++; if (obs_pop_src.size() != 1) begin bad++; $display("FAIL midrst_pops: got %0d want 1", obs_pop_src.size()); end
        total++; if (obs_bytes.size() != LINE_LEN) begin bad++; $display("FAIL midrst_len: got %0d want %0d", obs_bytes.size(), LINE_LEN); end
        nerr = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_q[k]) nerr++;
        total++; if (nerr != 0) begin bad++; $display("FAIL midrst_bytes: got %0d wrong bytes want 0", nerr); end
    endtask

    task automatic test_holdoff();
        bit to;
        int nerr;
        do_reset();
        stale_len = 1;
        src_q[0].push_back(WIDTH'($urandom));
        push_line(0, src_q[0][0]);
        drive_inputs();
        drain(80, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL holdoff_timeout: got %b want 0", to); end
        total++; if (obs_pop_src.size() != 1) begin bad++; $display("FAIL holdoff_pops: got %0d want 1", obs_pop_src.size()); end
        nerr = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || obs_bytes.size() != exp_q.size()) begin bad++; $display("FAIL holdoff_bytes: got %0d bytes (%0d wrong) want %0d", obs_bytes.size(), nerr, exp_q.size()); end
        stale_len = 0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] recs [NUM_SRC][$];
        int exp_src[$];
        int left [NUM_SRC];
        int ptr, remaining, pick, nerr;
        bit to;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            ready_mode = 1;
            exp_src.delete();
            remaining = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                recs[s].delete();
                left[s] = $urandom_range(1, 5);
                remaining += left[s];
                for (int r = 0; r < left[s]; r++) begin
                    recs[s].push_back(WIDTH'($urandom));
                    src_q[s].push_back(recs[s][r]);
                end
            end
            // All records are queued up front, so the serve order is the
            // round-robin walk over the non-empty sources.
            ptr = 0;
            while (remaining > 0) begin
                pick = -1;
                for (int off = 0; off < NUM_SRC && pick < 0; off++)
                    if (left[(ptr + off) % NUM_SRC] > 0) pick = (ptr + off) % NUM_SRC;
                exp_src.push_back(pick);
                push_line(pick, recs[pick].pop_front());
                left[pick]--;
                remaining--;
                ptr = (pick + 1) % NUM_SRC;
            end
            drive_inputs();
            drain(1000, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout: got %b want 0", round, to); end
            total++; if (viol != 0) begin bad++; $display("FAIL rand%0d_ready: got %0d want 0", round, viol); end
            total++; if (pop_bad != 0) begin bad++; $display("FAIL rand%0d_onehot: got %0d want 0", round, pop_bad); end
            total++; if (obs_pop_src.size() != exp_src.size()) begin bad++; $display("FAIL rand%0d_pops: got %0d want %0d", round, obs_pop_src.size(), exp_src.size()); end
            nerr = 0;
            for (int k = 0; k < exp_src.size(); k++)
                if (k >= obs_pop_src.size() || obs_pop_src[k] != exp_src[k]) nerr++;
            total++; if (nerr != 0) begin bad++; $display("FAIL rand%0d_order: got %0d wrong grants want 0", round, nerr); end
            total++; if (obs_bytes.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len: got %0d want %0d", round, obs_bytes.size(), exp_q.size()); end
            nerr = 0;
            for (int k = 0; k < exp_q.size(); k++)
                if (k >= obs_bytes.size() || obs_bytes[k] !== exp_q[k]) nerr++;
            total++; if (nerr != 0) begin bad++; $display("FAIL rand%0d_bytes: got %0d wrong bytes want 0", round, nerr); end
        end
        ready_mode = 0;
    endtask

`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
    task automatic test_tag();
        logic [7:0] exp_b [12];
        bit to;
        exp_b = '{8'h31, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h20, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A, 8'h0D};
        do_reset();
        src_q[1].push_back(28'h0000001);
        drive_inputs();
        drain(80, to);
        total++; if (obs_bytes.size() != 12) begin bad++; $display("FAIL tag_len: got %0d want 12", obs_bytes.size()); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (k >= obs_bytes.size() || obs_bytes[k] !== exp_b[k]) begin
                bad++;
                $display("FAIL tag_byte[%0d]: got %h want %h", k, (k < obs_bytes.size()) ? obs_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        src_available = '0;
        src_data      = '0;
        tx_ready      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) stale_cnt[i] = 0;
        test_reset();
        test_single_line();
        test_alternate();
        test_stall();
        test_mid_reset();
        test_holdoff();
        test_random();
`ifdef HEX_RECORD_ARBITER_SOURCE_TAG_EN
        test_tag();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
